rcpu_boot_loader: RTL and testbench
===================================

Name: rcpu_boot_loader

Overview:
- Sits between an external byte stream, the RAM write port and the rcpu memory bus.
- After reset, holds the CPU in reset and receives a framed program image byte by byte, writing it into RAM as 16-bit words from BASE_ADDR upward. It then verifies a checksum.
- On success it releases the CPU and hands the RAM bus over to the CPU. This replaces file-based preloading of program memory.

Parameters:
- BASE_ADDR, 16'h0000, RAM word address of the first loaded word.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- inData  in  8  incoming image byte
- inValid  in  1  inData holds a valid byte
- inReady  out  1  loader can accept a byte; transfer occurs when inValid && inReady at posedge
- cpuMemAddr  in  32  CPU bus address (from rcpu memAddr)
- cpuMemWrite  in  16  CPU write data
- cpuMemWE  in  1  CPU write enable
- cpuRst  out  1  reset to rcpu; 1 while loading or on error
- ramAddr  out  16  RAM address
- ramWData  out  16  RAM write data
- ramWE  out  1  RAM write enable
- done  out  1  image loaded and verified, CPU running
- error  out  1  checksum mismatch, sticky until rst

Behaviour:
- Frame format: CNT_HI, CNT_LO, then N words each sent as HI byte then LO byte, then CHK. N = {CNT_HI,CNT_LO}, range 0..65535.
- CHK must equal the XOR of every preceding frame byte, including the count bytes.
- States: COUNT_HI -> COUNT_LO -> (N==0 ? CHECK : DATA_HI) ; DATA_HI -> DATA_LO ; DATA_LO -> (last word ? CHECK : DATA_HI) ; CHECK -> (match ? RUN : ERROR) ; RUN and ERROR are terminal.
- A state advances only on a transfer. With inValid low, the state, counters and checksum hold.
- inReady = 1 in COUNT_HI..CHECK, 0 in RUN and ERROR. It is registered-state-derived and has no combinational path from inValid.
- Running XOR is cleared on reset and updated on every accepted byte before CHECK.
- Word assembly: the HI byte is latched. On the DATA_LO transfer, the next cycle drives ramWE=1, ramAddr=BASE_ADDR+wordIndex, ramWData={HI,LO} for exactly one cycle (1-cycle latency, registered).
- wordIndex increments after each write. Address arithmetic is modulo 2^16, so BASE_ADDR+index wraps past 16'hFFFF to 0.
- Back-to-back bytes every cycle are supported: one write at most every 2 cycles, with no stall needed.
- cpuRst = 1 in all states except RUN.
- done = 1 only in RUN. error = 1 only in ERROR.
- Entering RUN: the cycle after the CHK transfer, cpuRst=0 and done=1. The final data write has already completed, because CHK is accepted at least one cycle after the last DATA_LO.
- Bus mux in RUN is combinational: ramAddr=cpuMemAddr[15:0], ramWData=cpuMemWrite, ramWE=cpuMemWE.
- Outside RUN, CPU bus inputs are ignored. ramWE is 0 except for loader write pulses; ramAddr and ramWData hold their last loader values.
- ERROR: no RAM writes, inReady=0, cpuRst=1. The state persists until rst.
- Reset values: state COUNT_HI, inReady 1, cpuRst 1, ramWE 0, ramAddr BASE_ADDR, ramWData 0, done 0, error 0, checksum 0, wordIndex 0.
- Reset mid-load: returns to COUNT_HI immediately at that edge. A pending write pulse is cancelled (ramWE=0 the next cycle). Partial RAM contents are left as-is.
- Reset while in RUN: the CPU is re-held and loading restarts.

Test Plan:
- Stream 00 02 12 34 AB CD 42, one byte per cycle -> RAM[0]=16'h1234, RAM[1]=16'hABCD, each ramWE pulse 1 cycle long. The cycle after 42 is accepted: done=1, cpuRst=0, inReady=0.
- Same stream with check byte 43 -> error=1, done=0, cpuRst=1, inReady=0. No further RAM writes; error persists for 20+ cycles.
- Stream 00 00 00 (N=0) -> no ramWE pulses, RUN reached. Then CPU drives cpuMemAddr=32'h0000_0005, cpuMemWrite=16'hBEEF, cpuMemWE=1 -> ramAddr=5, ramWData=BEEF, ramWE=1 in the same cycle.
- First stream with inValid dropped for 3 cycles between every byte -> identical RAM contents and final state; no duplicate writes.
- BASE_ADDR=16'hFFFF with the first stream -> RAM[FFFF]=1234, RAM[0000]=ABCD (wrap).
- Assert rst after 00 02 12 34 AB have been accepted, then send the full first stream -> clean restart from COUNT_HI, RAM[0]=1234, RAM[1]=ABCD, done=1.

Source files
------------

// File: rtl/rcpu_boot_loader.sv
// Boot loader for rcpu: receives a framed program image over a byte stream,
// writes it into RAM as 16-bit words, verifies an XOR checksum and then
// releases the CPU and hands the RAM port over to the CPU memory bus.
//
// Frame: CNT_HI, CNT_LO, N x (HI, LO), CHK where CHK is the XOR of all
// preceding frame bytes.

module rcpu_boot_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  inData,
   input  logic        inValid,
   output logic        inReady,
   input  logic [31:0] cpuMemAddr,
   input  logic [15:0] cpuMemWrite,
   input  logic        cpuMemWE,
   output logic        cpuRst,
   output logic [15:0] ramAddr,
   output logic [15:0] ramWData,
   output logic        ramWE,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      StCountHi,
      StCountLo,
      StDataHi,
      StDataLo,
      StCheck,
      StRun,
      StError
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] count_q, count_d;      // number of words in the image
   logic [15:0] idx_q, idx_d;          // index of the next word to write
   logic [7:0]  hi_q, hi_d;            // latched high byte of current word
   logic [7:0]  xsum_q, xsum_d;        // running XOR of accepted frame bytes
   logic        wr_we_q, wr_we_d;      // loader write pulse
   logic [15:0] wr_addr_q, wr_addr_d;  // loader-side RAM address
   logic [15:0] wr_data_q, wr_data_d;  // loader-side RAM write data

   logic        xfer;
   logic        loading;

   // Upper CPU address bits do not reach the 16-bit RAM port.
   logic        unused_addr_hi;
   assign unused_addr_hi = ^cpuMemAddr[31:16];

   // Byte acceptance depends only on registered state, never on inValid.
   always_comb begin
      loading = 1'b0;
      unique case (state_q)
         StCountHi, StCountLo, StDataHi, StDataLo, StCheck: loading = 1'b1;
         default:                                           loading = 1'b0;
      endcase
   end

   assign inReady = loading;
   assign xfer    = inValid && loading;

   // Next-state logic: frame parsing, checksum accumulation, word assembly.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      idx_d     = idx_q;
      hi_d      = hi_q;
      xsum_d    = xsum_q;
      wr_we_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      unique case (state_q)
         StCountHi: begin
            if (xfer) begin
               count_d[15:8] = inData;
               xsum_d        = xsum_q ^ inData;
               state_d       = StCountLo;
            end
         end

         StCountLo: begin
            if (xfer) begin
               count_d[7:0] = inData;
               xsum_d       = xsum_q ^ inData;
               // An empty image goes straight to the checksum byte.
               if ({count_q[15:8], inData} == 16'h0000) begin
                  state_d = StCheck;
               end else begin
                  state_d = StDataHi;
               end
            end
         end

         StDataHi: begin
            if (xfer) begin
               hi_d    = inData;
               xsum_d  = xsum_q ^ inData;
               state_d = StDataLo;
            end
         end

         StDataLo: begin
            if (xfer) begin
               xsum_d    = xsum_q ^ inData;
               // Register the write so ramWE pulses for one cycle after LO.
               wr_we_d   = 1'b1;
               wr_addr_d = BASE_ADDR + idx_q;
               wr_data_d = {hi_q, inData};
               idx_d     = idx_q + 16'd1;
               if (idx_q + 16'd1 == count_q) begin
                  state_d = StCheck;
               end else begin
                  state_d = StDataHi;
               end
            end
         end

         StCheck: begin
            if (xfer) begin
               if (inData == xsum_q) begin
                  state_d = StRun;
               end else begin
                  state_d = StError;
               end
            end
         end

         StRun, StError: begin
            state_d = state_q;
         end

         default: begin
            state_d = StCountHi;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StCountHi;
         count_q   <= 16'h0000;
         idx_q     <= 16'h0000;
         hi_q      <= 8'h00;
         xsum_q    <= 8'h00;
         wr_we_q   <= 1'b0;
         wr_addr_q <= BASE_ADDR;
         wr_data_q <= 16'h0000;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         idx_q     <= idx_d;
         hi_q      <= hi_d;
         xsum_q    <= xsum_d;
         wr_we_q   <= wr_we_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Status outputs and RAM port mux: the CPU owns the port only in RUN.
   always_comb begin
      cpuRst   = 1'b1;
      done     = 1'b0;
      error    = 1'b0;
      ramAddr  = wr_addr_q;
      ramWData = wr_data_q;
      ramWE    = wr_we_q;
      unique case (state_q)
         StRun: begin
            cpuRst   = 1'b0;
            done     = 1'b1;
            ramAddr  = cpuMemAddr[15:0];
            ramWData = cpuMemWrite;
            ramWE    = cpuMemWE;
         end
         StError: begin
            error = 1'b1;
         end
         default: begin
            cpuRst = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_rcpu_boot_loader.sv
// Self-checking bench for rcpu_boot_loader. Two instances share the stimulus:
// one at BASE_ADDR 0 and one at 16'hFFFF to exercise address wrap. Expected
// RAM contents and final status come from the frame contents themselves.

module tb_rcpu_boot_loader;

   localparam logic [15:0] BASE0 = 16'h0000;
   localparam logic [15:0] BASE1 = 16'hFFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  inData;
   logic        inValid;
   logic [31:0] cpuMemAddr;
   logic [15:0] cpuMemWrite;
   logic        cpuMemWE;

   logic        inReady0, cpuRst0, ramWE0, done0, error0;
   logic [15:0] ramAddr0, ramWData0;
   logic        inReady1, cpuRst1, ramWE1, done1, error1;
   logic [15:0] ramAddr1, ramWData1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   rcpu_boot_loader #(.BASE_ADDR(BASE0)) dut0 (
      .clk(clk), .rst(rst), .inData(inData), .inValid(inValid), .inReady(inReady0),
      .cpuMemAddr(cpuMemAddr), .cpuMemWrite(cpuMemWrite), .cpuMemWE(cpuMemWE),
      .cpuRst(cpuRst0), .ramAddr(ramAddr0), .ramWData(ramWData0), .ramWE(ramWE0),
      .done(done0), .error(error0)
   );

   rcpu_boot_loader #(.BASE_ADDR(BASE1)) dut1 (
      .clk(clk), .rst(rst), .inData(inData), .inValid(inValid), .inReady(inReady1),
      .cpuMemAddr(cpuMemAddr), .cpuMemWrite(cpuMemWrite), .cpuMemWE(cpuMemWE),
      .cpuRst(cpuRst1), .ramAddr(ramAddr1), .ramWData(ramWData1), .ramWE(ramWE1),
      .done(done1), .error(error1)
   );

   // Behavioural RAMs, sampled on the falling edge, with write counters.
   logic [15:0] ram0 [logic [15:0]];
   logic [15:0] ram1 [logic [15:0]];
   int          wc0 = 0;
   int          wc1 = 0;
   bit          clr_req = 1'b0;

   always @(negedge clk) begin
      if (clr_req) begin
         ram0.delete();
         ram1.delete();
         wc0 = 0;
         wc1 = 0;
      end else begin
         if (ramWE0 === 1'b1) begin
            ram0[ramAddr0] = ramWData0;
            wc0++;
         end
         if (ramWE1 === 1'b1) begin
            ram1[ramAddr1] = ramWData1;
            wc1++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      inValid  = 1'b0;
      inData   = 8'h00;
      cpuMemWE = 1'b0;
      cyc();
      clr_req = 1'b1;
      cyc();
      rst     = 1'b0;
      clr_req = 1'b0;
   endtask

   task automatic check_reset();
      chk("rst_inReady", {inReady1, inReady0}, 32'd3);
      chk("rst_cpuRst", {cpuRst1, cpuRst0}, 32'd3);
      chk("rst_ramWE", {ramWE1, ramWE0}, 32'd0);
      chk("rst_ramAddr0", ramAddr0, BASE0);
      chk("rst_ramAddr1", ramAddr1, BASE1);
      chk("rst_ramWData", {ramWData1, ramWData0}, 32'd0);
      chk("rst_done_error", {done1, done0, error1, error0}, 32'd0);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
      for (int g = 0; g < gap; g++) begin
         inValid = 1'b0;
         inData  = 8'($urandom);
         if (noise) begin
            cpuMemWE    = 1'($urandom);
            cpuMemAddr  = $urandom;
            cpuMemWrite = 16'($urandom);
         end
         cyc();
      end
      inValid = 1'b1;
      inData  = b;
      if (noise) begin
         cpuMemWE    = 1'($urandom);
         cpuMemAddr  = $urandom;
         cpuMemWrite = 16'($urandom);
      end
      chk("in_ready", {inReady1, inReady0}, 32'd3);
      cyc();
   endtask

   // Builds a frame from words, streams it, and checks writes and final status.
   task automatic run_frame(input logic [15:0] w[$], input int gmin, input int gmax,
                            input bit bad, input bit noise);
      logic [7:0]  bytes[$];
      logic [7:0]  x;
      logic [15:0] nn;
      logic [15:0] a;
      int          n;
      int          gap;
      bit          good;
      n  = w.size();
      nn = 16'(n);
      bytes.push_back(nn[15:8]);
      bytes.push_back(nn[7:0]);
      foreach (w[i]) begin
         bytes.push_back(w[i][15:8]);
         bytes.push_back(w[i][7:0]);
      end
      x = 8'h00;
      foreach (bytes[i]) x = x ^ bytes[i];
      bytes.push_back(bad ? (x ^ 8'h01) : x);
      good = !bad;

      do_reset();
      check_reset();
      for (int k = 0; k < bytes.size(); k++) begin
         gap = int'($urandom_range(gmax, gmin));
         if (k == bytes.size() - 1) begin
            cpuMemWE = 1'b0;
            send_byte(bytes[k], gap, 1'b0);
         end else begin
            send_byte(bytes[k], gap, noise);
         end
         if (k >= 3 && k < bytes.size() - 1 && (k % 2) == 1) begin
            chk("wr_pulse", {ramWE1, ramWE0}, 32'd3);
            chk("wr_addr0", ramAddr0, 16'(BASE0 + 16'((k - 3) / 2)));
            chk("wr_addr1", ramAddr1, 16'(BASE1 + 16'((k - 3) / 2)));
            chk("wr_data", {ramWData1, ramWData0}, {w[(k - 3) / 2], w[(k - 3) / 2]});
         end
      end
      cpuMemWE = 1'b0;
      inValid  = 1'b0;
      chk("end_done", {done1, done0}, good ? 32'd3 : 32'd0);
      chk("end_error", {error1, error0}, good ? 32'd0 : 32'd3);
      chk("end_cpuRst", {cpuRst1, cpuRst0}, good ? 32'd0 : 32'd3);
      chk("end_inReady", {inReady1, inReady0}, 32'd0);

      // Terminal state must ignore further bytes.
      for (int c = 0; c < 20; c++) begin
         inValid = 1'b1;
         inData  = 8'($urandom);
         cyc();
      end
      inValid = 1'b0;
      chk("hold_done", {done1, done0}, good ? 32'd3 : 32'd0);
      chk("hold_error", {error1, error0}, good ? 32'd0 : 32'd3);
      chk("hold_cpuRst", {cpuRst1, cpuRst0}, good ? 32'd0 : 32'd3);
      chk("write_count0", wc0, n);
      chk("write_count1", wc1, n);
      for (int i = 0; i < n; i++) begin
         a = BASE0 + 16'(i);
         chk("ram0", ram0.exists(a) ? {16'h0, ram0[a]} : 32'h0001_0000, {16'h0, w[i]});
         a = BASE1 + 16'(i);
         chk("ram1", ram1.exists(a) ? {16'h0, ram1[a]} : 32'h0001_0000, {16'h0, w[i]});
      end
   endtask

   initial begin
      logic [15:0] q[$];
      int          n;
      cpuMemAddr  = 32'h0;
      cpuMemWrite = 16'h0;
      cpuMemWE    = 1'b0;
      inData      = 8'h00;
      inValid     = 1'b0;
      rst         = 1'b1;

      // Nominal image, one byte per cycle.
      q = '{16'h1234, 16'hABCD};
      run_frame(q, 0, 0, 1'b0, 1'b0);

      // Corrupted checksum byte.
      run_frame(q, 0, 0, 1'b1, 1'b0);

      // Empty image, then CPU bus takes the RAM port combinationally.
      q.delete();
      run_frame(q, 0, 0, 1'b0, 1'b0);
      cpuMemAddr  = 32'h0000_0005;
      cpuMemWrite = 16'hBEEF;
      cpuMemWE    = 1'b1;
      #1;
      chk("cpu_addr0", ramAddr0, 16'h0005);
      chk("cpu_addr1", ramAddr1, 16'h0005);
      chk("cpu_wdata", {ramWData1, ramWData0}, 32'hBEEF_BEEF);
      chk("cpu_we", {ramWE1, ramWE0}, 32'd3);
      cpuMemWE = 1'b0;
      #1;
      chk("cpu_we_low", {ramWE1, ramWE0}, 32'd0);
      cyc();

      // Three idle cycles before every byte, with CPU bus noise while loading.
      q = '{16'h1234, 16'hABCD};
      run_frame(q, 3, 3, 1'b0, 1'b1);

      // Reset coincident with a LO transfer cancels the pending write.
      do_reset();
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h02, 0, 1'b0);
      send_byte(8'h12, 0, 1'b0);
      inValid = 1'b1;
      inData  = 8'h34;
      rst     = 1'b1;
      cyc();
      chk("cancel_we", {ramWE1, ramWE0}, 32'd0);
      chk("cancel_ready", {inReady1, inReady0}, 32'd3);
      rst     = 1'b0;
      inValid = 1'b0;
      cyc();
      chk("cancel_count", wc0 + wc1, 32'd0);

      // Partial load interrupted by reset, then a full reload.
      do_reset();
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h02, 0, 1'b0);
      send_byte(8'h12, 0, 1'b0);
      send_byte(8'h34, 0, 1'b0);
      send_byte(8'hAB, 0, 1'b0);
      inValid = 1'b0;
      q = '{16'h1234, 16'hABCD};
      run_frame(q, 0, 0, 1'b0, 1'b0);

      // Randomized images, gaps, checksum corruption and CPU bus noise.
      for (int t = 0; t < 10; t++) begin
         q.delete();
         n = int'($urandom_range(6, 1));
         for (int i = 0; i < n; i++) q.push_back(16'($urandom));
         run_frame(q, 0, int'($urandom_range(2, 0)), ($urandom_range(3, 0) == 0), 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
